// File: rtl/ring_input_buffer.sv
// Input staging buffer for one ring router output port: high-priority ring slots and low-priority injection slots.
// Define RING_BUF_STATS_EN to add saturating drop/accept statistics counters.
module ring_input_buffer #(
   parameter int PACKET_SIZE = 49,
   parameter int BUFFER_SIZE = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [PACKET_SIZE-1:0]                  ring_in_packet,
   input  logic [15:0]                             ring_in_route_info,
   output logic                                    ring_full,
   output logic                                    ring_drop,
   input  logic                                    inj_valid,
   output logic                                    inj_ready,
   input  logic [PACKET_SIZE-1:0]                  inj_packet,
   input  logic [15:0]                             inj_route_info,
   output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_high_prior,
   output logic [BUFFER_SIZE-1:0][15:0]            buffer_high_prior_route_info,
   output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_low_prior,
   output logic [BUFFER_SIZE-1:0][15:0]            buffer_low_prior_route_info,
   input  logic [15:0]                             out_packet_pos,
   input  logic                                    out_packet_pos_valid,
   input  logic                                    out_packet_pos_in_high,
   output logic [$clog2(BUFFER_SIZE):0]            high_count,
   output logic [$clog2(BUFFER_SIZE):0]            low_count
`ifdef RING_BUF_STATS_EN
   ,
   output logic [15:0]                             ring_drop_cnt,
   output logic [15:0]                             inj_accept_cnt
`endif
);

   localparam int IW = $clog2(BUFFER_SIZE);
   localparam int CW = IW + 1;

   logic [BUFFER_SIZE-1:0] high_occ;
   logic [BUFFER_SIZE-1:0] low_occ;
   logic [BUFFER_SIZE-1:0] high_rel;
   logic [BUFFER_SIZE-1:0] low_rel;
   logic [BUFFER_SIZE-1:0] ring_avail;
   logic [IW-1:0]          rel_idx;
   logic [IW-1:0]          ring_idx;
   logic [IW-1:0]          inj_idx;
   logic                   ring_found;
   logic                   inj_found;
   logic                   ring_arrival;
   logic                   ring_wr;
   logic                   ring_discard;
   logic                   inj_wr;
   logic                   high_eff_rel;
   logic                   low_eff_rel;
   logic [15:0]            ts_cnt;
   logic [PACKET_SIZE-1:0] inj_stamped;
   logic [15:0]            unused_pos_bits;

   assign unused_pos_bits = out_packet_pos;
   assign rel_idx         = out_packet_pos[IW-1:0];
   assign ring_arrival    = ring_in_packet[PACKET_SIZE-1];

   // A released slot may be refilled by a ring arrival in the same cycle, but injection
   // only looks at current occupancy so inj_ready never depends on the allocator grant.
   always_comb begin
      high_rel   = '0;
      low_rel    = '0;
      ring_found = 1'b0;
      ring_idx   = '0;
      inj_found  = 1'b0;
      inj_idx    = '0;
      for (int i = 0; i < BUFFER_SIZE; i++) begin
         high_occ[i] = buffer_high_prior[i][PACKET_SIZE-1];
         low_occ[i]  = buffer_low_prior[i][PACKET_SIZE-1];
      end
      high_rel[rel_idx] = out_packet_pos_valid & out_packet_pos_in_high;
      low_rel[rel_idx]  = out_packet_pos_valid & ~out_packet_pos_in_high;
      ring_avail = ~high_occ | high_rel;
      for (int i = BUFFER_SIZE - 1; i >= 0; i--) begin
         if (ring_avail[i]) begin
            ring_found = 1'b1;
            ring_idx   = IW'(i);
         end
         if (!low_occ[i]) begin
            inj_found = 1'b1;
            inj_idx   = IW'(i);
         end
      end
      inj_stamped                  = inj_packet;
      inj_stamped[PACKET_SIZE-1]   = 1'b1;
      inj_stamped[47:32]           = ts_cnt;
   end

   assign ring_wr      = ring_arrival & ring_found;
   assign ring_discard = ring_arrival & ~ring_found;
   assign inj_ready    = inj_found;
   assign inj_wr       = inj_valid & inj_found;
   assign high_eff_rel = |(high_rel & high_occ);
   assign low_eff_rel  = |(low_rel & low_occ);
   assign ring_full    = &high_occ;

   // Release is applied before the write so a ring arrival into a just-granted slot wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         buffer_high_prior            <= '0;
         buffer_high_prior_route_info <= '0;
         buffer_low_prior             <= '0;
         buffer_low_prior_route_info  <= '0;
         high_count                   <= '0;
         low_count                    <= '0;
         ts_cnt                       <= '0;
         ring_drop                    <= 1'b0;
      end else begin
         ts_cnt    <= ts_cnt + 16'd1;
         ring_drop <= ring_discard;
         if (|high_rel) begin
            buffer_high_prior[rel_idx]            <= '0;
            buffer_high_prior_route_info[rel_idx] <= '0;
         end
         if (|low_rel) begin
            buffer_low_prior[rel_idx]            <= '0;
            buffer_low_prior_route_info[rel_idx] <= '0;
         end
         if (ring_wr) begin
            buffer_high_prior[ring_idx]            <= ring_in_packet;
            buffer_high_prior_route_info[ring_idx] <= ring_in_route_info;
         end
         if (inj_wr) begin
            buffer_low_prior[inj_idx]            <= inj_stamped;
            buffer_low_prior_route_info[inj_idx] <= inj_route_info;
         end
         high_count <= high_count + CW'(ring_wr) - CW'(high_eff_rel);
         low_count  <= low_count + CW'(inj_wr) - CW'(low_eff_rel);
      end
   end

`ifdef RING_BUF_STATS_EN
   // Statistics saturate rather than wrap so a long run never reports a small number.
   always_ff @(posedge clk) begin
      if (rst) begin
         ring_drop_cnt  <= '0;
         inj_accept_cnt <= '0;
      end else begin
         if (ring_discard && ring_drop_cnt != 16'hFFFF)
            ring_drop_cnt <= ring_drop_cnt + 16'd1;
         if (inj_wr && inj_accept_cnt != 16'hFFFF)
            inj_accept_cnt <= inj_accept_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ring_input_buffer.sv
// Directed, table-driven bench for ring_input_buffer (default build) plus a timestamp wrap sequence.
module tb_ring_input_buffer;

   localparam int PS = 49;
   localparam int BS = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [PS-1:0]     ring_in_packet;
   logic [15:0]       ring_in_route_info;
   logic              ring_full;
   logic              ring_drop;
   logic              inj_valid;
   logic              inj_ready;
   logic [PS-1:0]     inj_packet;
   logic [15:0]       inj_route_info;
   logic [BS-1:0][PS-1:0] buffer_high_prior;
   logic [BS-1:0][15:0]   buffer_high_prior_route_info;
   logic [BS-1:0][PS-1:0] buffer_low_prior;
   logic [BS-1:0][15:0]   buffer_low_prior_route_info;
   logic [15:0]       out_packet_pos;
   logic              out_packet_pos_valid;
   logic              out_packet_pos_in_high;
   logic [2:0]        high_count;
   logic [2:0]        low_count;

   int nVectors = 0;
   int nMiss    = 0;

   ring_input_buffer #(.PACKET_SIZE(PS), .BUFFER_SIZE(BS)) dut (
      .clk                          (clk),
      .rst                          (rst),
      .ring_in_packet               (ring_in_packet),
      .ring_in_route_info           (ring_in_route_info),
      .ring_full                    (ring_full),
      .ring_drop                    (ring_drop),
      .inj_valid                    (inj_valid),
      .inj_ready                    (inj_ready),
      .inj_packet                   (inj_packet),
      .inj_route_info               (inj_route_info),
      .buffer_high_prior            (buffer_high_prior),
      .buffer_high_prior_route_info (buffer_high_prior_route_info),
      .buffer_low_prior             (buffer_low_prior),
      .buffer_low_prior_route_info  (buffer_low_prior_route_info),
      .out_packet_pos               (out_packet_pos),
      .out_packet_pos_valid         (out_packet_pos_valid),
      .out_packet_pos_in_high       (out_packet_pos_in_high),
      .high_count                   (high_count),
      .low_count                    (low_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rv;
      logic [15:0] rtag;
      logic        iv;
      logic [15:0] itag;
      logic        gv;
      logic        gh;
      logic [15:0] gpos;
      logic        eFull;
      logic        eDrop;
      logic        eRdy;
      logic [2:0]  eHc;
      logic [2:0]  eLc;
      logic [1:0]  arr;
      logic [1:0]  slot;
      logic [PS-1:0] ePkt;
      logic [15:0] eRoute;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [PS-1:0] rp(input logic [15:0] tag);
      return {1'b1, 16'h5A5A, 16'h0000, tag};
   endfunction

   function automatic logic [PS-1:0] sp(input logic [15:0] stamp, input logic [15:0] tag);
      return {1'b1, stamp, 16'h0000, tag};
   endfunction

   function automatic vec_t mk(
      input logic r, input logic rv, input logic [15:0] rtag,
      input logic iv, input logic [15:0] itag,
      input logic gv, input logic gh, input logic [15:0] gpos,
      input logic full, input logic drop, input logic rdy,
      input logic [2:0] hc, input logic [2:0] lc,
      input logic [1:0] arr, input logic [1:0] slot,
      input logic [PS-1:0] pkt, input logic [15:0] route);
      vec_t v;
      v.rst = r; v.rv = rv; v.rtag = rtag; v.iv = iv; v.itag = itag;
      v.gv = gv; v.gh = gh; v.gpos = gpos;
      v.eFull = full; v.eDrop = drop; v.eRdy = rdy; v.eHc = hc; v.eLc = lc;
      v.arr = arr; v.slot = slot; v.ePkt = pkt; v.eRoute = route;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst                    = v.rst;
      ring_in_packet         = {v.rv, 16'h5A5A, 16'h0000, v.rtag};
      ring_in_route_info     = v.rtag;
      inj_valid              = v.iv;
      inj_packet             = {1'b0, 16'hABCD, 16'h0000, v.itag};
      inj_route_info         = v.itag + 16'h0100;
      out_packet_pos_valid   = v.gv;
      out_packet_pos_in_high = v.gh;
      out_packet_pos         = v.gpos;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      nVectors++;
      cmp("ring_full", idx, 64'(ring_full), 64'(v.eFull));
      cmp("ring_drop", idx, 64'(ring_drop), 64'(v.eDrop));
      cmp("inj_ready", idx, 64'(inj_ready), 64'(v.eRdy));
      cmp("high_count", idx, 64'(high_count), 64'(v.eHc));
      cmp("low_count", idx, 64'(low_count), 64'(v.eLc));
      if (v.arr == 2'd1) begin
         cmp("high_slot", idx, 64'(buffer_high_prior[v.slot]), 64'(v.ePkt));
         cmp("high_route", idx, 64'(buffer_high_prior_route_info[v.slot]), 64'(v.eRoute));
      end else if (v.arr == 2'd2) begin
         cmp("low_slot", idx, 64'(buffer_low_prior[v.slot]), 64'(v.ePkt));
         cmp("low_route", idx, 64'(buffer_low_prior_route_info[v.slot]), 64'(v.eRoute));
      end
   endtask

   initial begin
      // reset, fill low with stamps 0..3
      vecs.push_back(mk(1, 0,16'h0,  0,16'h0, 0,0,16'h0, 0,0,1,3'd0,3'd0, 2,0, '0, 16'h0));
      vecs.push_back(mk(0, 0,16'h0,  1,16'h1, 0,0,16'h0, 0,0,1,3'd0,3'd1, 2,0, sp(16'h0000,16'h1), 16'h0101));
      vecs.push_back(mk(0, 0,16'h0,  1,16'h2, 0,0,16'h0, 0,0,1,3'd0,3'd2, 2,1, sp(16'h0001,16'h2), 16'h0102));
      vecs.push_back(mk(0, 0,16'h0,  1,16'h3, 0,0,16'h0, 0,0,1,3'd0,3'd3, 2,2, sp(16'h0002,16'h3), 16'h0103));
      vecs.push_back(mk(0, 0,16'h0,  1,16'h4, 0,0,16'h0, 0,0,0,3'd0,3'd4, 2,3, sp(16'h0003,16'h4), 16'h0104));
      vecs.push_back(mk(0, 0,16'h0,  0,16'h0, 0,0,16'h0, 0,0,0,3'd0,3'd4, 2,0, sp(16'h0000,16'h1), 16'h0101));
      // fill high, then overflow
      vecs.push_back(mk(0, 1,16'h10, 0,16'h0, 0,0,16'h0, 0,0,0,3'd1,3'd4, 1,0, rp(16'h10), 16'h10));
      vecs.push_back(mk(0, 1,16'h11, 0,16'h0, 0,0,16'h0, 0,0,0,3'd2,3'd4, 1,1, rp(16'h11), 16'h11));
      vecs.push_back(mk(0, 1,16'h12, 0,16'h0, 0,0,16'h0, 0,0,0,3'd3,3'd4, 1,2, rp(16'h12), 16'h12));
      vecs.push_back(mk(0, 1,16'h13, 0,16'h0, 0,0,16'h0, 1,0,0,3'd4,3'd4, 1,3, rp(16'h13), 16'h13));
      vecs.push_back(mk(0, 1,16'h14, 0,16'h0, 0,0,16'h0, 1,1,0,3'd4,3'd4, 1,3, rp(16'h13), 16'h13));
      vecs.push_back(mk(0, 0,16'h0,  0,16'h0, 0,0,16'h0, 1,0,0,3'd4,3'd4, 1,0, rp(16'h10), 16'h10));
      // same-cycle release and refill, upper pos bits ignored
      vecs.push_back(mk(0, 1,16'h20, 0,16'h0, 1,1,16'h2, 1,0,0,3'd4,3'd4, 1,2, rp(16'h20), 16'h20));
      vecs.push_back(mk(0, 0,16'h0,  0,16'h0, 1,1,16'h5, 0,0,0,3'd3,3'd4, 1,1, '0, 16'h0));
      vecs.push_back(mk(0, 1,16'h21, 0,16'h0, 0,0,16'h0, 1,0,0,3'd4,3'd4, 1,1, rp(16'h21), 16'h21));
      // low release blocks same-cycle injection
      vecs.push_back(mk(0, 0,16'h0,  1,16'h5, 1,0,16'h0, 1,0,1,3'd4,3'd3, 2,0, '0, 16'h0));
      vecs.push_back(mk(0, 0,16'h0,  1,16'h6, 0,0,16'h0, 1,0,0,3'd4,3'd4, 2,0, sp(16'h000F,16'h6), 16'h0106));
      vecs.push_back(mk(0, 0,16'h0,  0,16'h0, 1,0,16'h1, 1,0,1,3'd4,3'd3, 2,1, '0, 16'h0));
      vecs.push_back(mk(0, 0,16'h0,  0,16'h0, 1,0,16'h1, 1,0,1,3'd4,3'd3, 2,1, '0, 16'h0));
      vecs.push_back(mk(0, 0,16'h0,  0,16'h0, 1,1,16'h0, 0,0,1,3'd3,3'd3, 1,0, '0, 16'h0));
      vecs.push_back(mk(0, 0,16'h99, 0,16'h0, 1,1,16'h0, 0,0,1,3'd3,3'd3, 1,0, '0, 16'h0));
      vecs.push_back(mk(0, 1,16'h40, 1,16'h7, 0,0,16'h0, 1,0,0,3'd4,3'd4, 2,1, sp(16'h0014,16'h7), 16'h0107));
      // mid-operation reset discards everything
      vecs.push_back(mk(1, 1,16'h50, 1,16'h8, 1,1,16'h2, 0,0,1,3'd0,3'd0, 1,2, '0, 16'h0));
      vecs.push_back(mk(0, 0,16'h77, 0,16'h0, 0,0,16'h0, 0,0,1,3'd0,3'd0, 1,0, '0, 16'h0));

      #2;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end

      // timestamp wrap: counter is k after k edges past reset
      rst = 1'b1; inj_valid = 1'b0; ring_in_packet = '0; out_packet_pos_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (16'hFFFE) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         inj_valid      = 1'b1;
         inj_packet     = {1'b0, 16'hABCD, 16'h0000, 16'(16'hA1 + k)};
         inj_route_info = 16'(16'hA1 + k);
         @(posedge clk); #1;
      end
      inj_valid = 1'b0;
      nVectors++;
      cmp("wrap_stamp0", 100, 64'(buffer_low_prior[0]), 64'(sp(16'hFFFE, 16'hA1)));
      cmp("wrap_stamp1", 101, 64'(buffer_low_prior[1]), 64'(sp(16'hFFFF, 16'hA2)));
      cmp("wrap_stamp2", 102, 64'(buffer_low_prior[2]), 64'(sp(16'h0000, 16'hA3)));
      cmp("wrap_route2", 103, 64'(buffer_low_prior_route_info[2]), 64'(16'hA3));
      cmp("wrap_lc", 104, 64'(low_count), 64'(3'd3));
      cmp("wrap_rdy", 105, 64'(inj_ready), 64'(1'b1));

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule

// File: doc/ring_input_buffer.md
Name: ring_input_buffer

Overview:
- Per-output-port input staging block that feeds the switch allocator in the ring router.
- Holds in-transit ring packets (high priority) and locally injected packets (low priority) in BUFFER_SIZE slots each, and presents both slot arrays plus per-slot route info.
- Releases a slot when the allocator reports the granted position.
- Stamps local packets with the age timestamp the allocator uses for oldest-first selection.

Parameters:
- PACKET_SIZE, 49: packet width. Bit PACKET_SIZE-1 is the valid bit; bits [47:32] are the age timestamp. Must be >= 49.
- BUFFER_SIZE, 4: slots per priority class. Power of two, >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ring_in_packet  input  PACKET_SIZE  ring arrival; valid when MSB=1
- ring_in_route_info  input  16  route info for ring arrival
- ring_full  output  1  no free high slot in current state
- ring_drop  output  1  one-cycle pulse: a ring arrival was discarded
- inj_valid  input  1  local injection request
- inj_ready  output  1  local injection accepted when inj_valid & inj_ready
- inj_packet  input  PACKET_SIZE  local packet; MSB and [47:32] are overwritten on store
- inj_route_info  input  16  route info for local packet
- buffer_high_prior  output  PACKET_SIZE x BUFFER_SIZE  high slot contents
- buffer_high_prior_route_info  output  16 x BUFFER_SIZE  high slot route info
- buffer_low_prior  output  PACKET_SIZE x BUFFER_SIZE  low slot contents
- buffer_low_prior_route_info  output  16 x BUFFER_SIZE  low slot route info
- out_packet_pos  input  16  granted slot index from allocator
- out_packet_pos_valid  input  1  grant valid; slot is to be released
- out_packet_pos_in_high  input  1  1 = grant in high array, 0 = low array
- high_count  output  $clog2(BUFFER_SIZE)+1  occupied high slots
- low_count  output  $clog2(BUFFER_SIZE)+1  occupied low slots

Behaviour:
- Reset (rst=1 at posedge): all slot contents and route info go to 0, counts 0, timestamp counter 0, ring_drop 0. After reset, ring_full=0 and inj_ready=1.
- Slot occupancy is the MSB of each slot. A free slot holds all-zero packet and zero route info.
- Release: on posedge with out_packet_pos_valid=1, the slot at out_packet_pos[$clog2(BUFFER_SIZE)-1:0] in the array selected by out_packet_pos_in_high is cleared (packet and route info to 0).
  - Upper index bits are ignored.
  - Releasing an already-free slot is a no-op; counts are unchanged.
- Ring write:
  - Triggered when ring_in_packet MSB=1.
  - Target slot is the lowest-index slot that is free in the current state or being released this same cycle.
  - Packet is stored unmodified, route info from ring_in_route_info. Takes effect at the next posedge (1-cycle latency).
  - If no such slot exists, the packet is discarded and ring_drop=1 in the next cycle.
- Injection write:
  - inj_ready = any low slot free in current state. A same-cycle release does not count, so there is no combinational path from the allocator grant.
  - On accept, the lowest free low slot is written with inj_packet, MSB forced to 1 and [47:32] replaced by the timestamp counter value.
- Timestamp counter: 16-bit, +1 every cycle, wraps 0xFFFF->0x0000. Ordering across wrap is not corrected.
- Counts update every posedge: count_next = count + write - effective_release, where effective_release means the slot was occupied. Simultaneous write and release on a full array leaves the count unchanged.
- ring_full is combinational from current occupancy: all high slots occupied.
- Slot outputs are register outputs; no combinational path from write inputs to slot outputs.
- Reset mid-operation: every stored packet is discarded, in-flight grants are ignored, and the counter restarts at 0.

Optional Feature:
- RING_BUF_STATS_EN defined: adds outputs ring_drop_cnt[15:0] and inj_accept_cnt[15:0].
  - Both are reset to 0.
  - Each saturates at 0xFFFF (no wrap).
  - ring_drop_cnt increments per discarded ring packet; inj_accept_cnt increments per injection handshake.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then inject 4 low packets on consecutive cycles starting at counter value 0 -> slots 0..3 hold [47:32] = 0,1,2,3 with MSB=1; low_count=4; inj_ready=0 from the cycle after the 4th accept.
- 4 ring packets fill high; 5th arrives with no release -> 5th is not stored, ring_drop=1 for exactly one cycle, high_count stays 4, ring_full=1.
- High array full; ring packet arrives in the same cycle as grant pos=2, in_high=1 -> slot 2 holds the new packet, high_count stays 4, no drop.
- Grant pos=1, in_high=0 for a free low slot -> no state change, low_count unchanged.
- Low array full; grant pos=0, in_high=0 and inj_valid=1 in the same cycle -> inj_ready=0 so the injection is not taken; next cycle inj_ready=1 and injection fills slot 0.
- Let the counter reach 0xFFFE, then inject on 3 consecutive cycles -> stamps 0xFFFE, 0xFFFF, 0x0000.
